// File: rtl/bitonic_sort_seq.sv
// Block bitonic sorter: buffers N words, walks the full bitonic network with a
// single compare-swap unit (issue one pair per cycle), then streams the block out.
module bitonic_sort_seq #(
  parameter int WIDTH     = 32,
  parameter int N         = 8,
  parameter bit ASCENDING = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int LG = $clog2(N);
  localparam logic [LG-1:0] LAST_IDX  = LG'(N - 1);
  localparam logic [LG-1:0] LAST_PAIR = LG'(N / 2 - 1);
  localparam logic [LG:0]   K_FIRST   = (LG + 1)'(2);
  localparam logic [LG:0]   K_LAST    = (LG + 1)'(N);

  typedef enum logic [1:0] {LOAD, SORT, UNLOAD} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [N];
  logic [LG-1:0]    wr_idx, rd_idx, p;
  logic [LG:0]      k;
  logic [LG-1:0]    j;
  logic             bubble;

  logic             wb_valid;
  logic [WIDTH-1:0] a_q, b_q;
  logic [LG-1:0]    lo_idx, hi_idx;

  logic [LG-1:0]    j_mask, pair_lo, pair_hi;
  logic             pair_asc;
  logic             swap;

  // Lower index is p with a zero spliced in at bit log2(j); its partner sits j above.
  always_comb begin
    j_mask   = j - LG'(1);
    pair_lo  = ((p & ~j_mask) << 1) | (p & j_mask);
    pair_hi  = pair_lo | j;
    pair_asc = ((({1'b0, pair_lo} & k) == '0) == ASCENDING);
    swap     = (b_q < a_q);
  end

  // NOTE: the block buffer carries no reset; every entry is rewritten by LOAD before it is read.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) mem[wr_idx] <= in_data;
    if (wb_valid) begin
      mem[lo_idx] <= swap ? b_q : a_q;
      mem[hi_idx] <= swap ? a_q : b_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      wr_idx    <= '0;
      rd_idx    <= '0;
      p         <= '0;
      k         <= '0;
      j         <= '0;
      bubble    <= 1'b0;
      wb_valid  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      lo_idx    <= '0;
      hi_idx    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      unique case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            if (wr_idx == LAST_IDX) begin
              state    <= SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              wr_idx   <= '0;
              k        <= K_FIRST;
              j        <= LG'(1);
              p        <= '0;
              bubble   <= 1'b0;
            end else begin
              wr_idx <= wr_idx + LG'(1);
            end
          end
        end

        SORT: begin
          if (!bubble) begin
            // Min always lands on the first-fed index, so direction is chosen at issue.
            wb_valid <= 1'b1;
            a_q      <= pair_asc ? mem[pair_lo] : mem[pair_hi];
            b_q      <= pair_asc ? mem[pair_hi] : mem[pair_lo];
            lo_idx   <= pair_asc ? pair_lo : pair_hi;
            hi_idx   <= pair_asc ? pair_hi : pair_lo;
            if (p == LAST_PAIR) begin
              p      <= '0;
              bubble <= 1'b1;
            end else begin
              p <= p + LG'(1);
            end
          end else begin
            // Bubble: the pass's last writeback lands this cycle, so step the pass here.
            bubble <= 1'b0;
            if (j == LG'(1)) begin
              if (k == K_LAST) begin
                state <= UNLOAD;
              end else begin
                k <= k << 1;
                j <= k[LG-1:0];
              end
            end else begin
              j <= j >> 1;
            end
          end
        end

        UNLOAD: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= mem[rd_idx];
          end else if (out_ready) begin
            if (rd_idx == LAST_IDX) begin
              state     <= LOAD;
              rd_idx    <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              rd_idx   <= rd_idx + LG'(1);
              out_data <= mem[rd_idx + LG'(1)];
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_bitonic_sort_seq.sv
// Self-checking bench for bitonic_sort_seq: table vectors, hand-written corner
// sequences, randomized blocks against a queue-based insertion-sort model.
module tb_bitonic_sort_seq;

  typedef logic [31:0] word_t;
  typedef word_t wq_t[$];
  typedef struct packed {
    logic [0:7][31:0] din;
    logic [0:7][31:0] asc;
    logic [0:7][31:0] dsc;
  } vec_t;

  logic  clk;
  logic  rst;
  logic  in_valid, out_ready;
  word_t in_data;
  logic  in_ready, out_valid, busy;
  word_t out_data;
  logic  in_ready_d, out_valid_d, busy_d;
  word_t out_data_d;
  logic  in2_valid, out2_ready, in2_ready, out2_valid, busy2;
  word_t in2_data, out2_data;
  logic  in3_valid, out3_ready, in3_ready, out3_valid, busy3;
  word_t in3_data, out3_data;

  int vectors = 0;
  int miscompares = 0;
  vec_t vecs[4];

  bitonic_sort_seq #(.WIDTH(32), .N(8), .ASCENDING(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

  bitonic_sort_seq #(.WIDTH(32), .N(8), .ASCENDING(1'b0)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d), .in_data(in_data),
    .out_valid(out_valid_d), .out_ready(out_ready), .out_data(out_data_d), .busy(busy_d));

  bitonic_sort_seq #(.WIDTH(32), .N(2), .ASCENDING(1'b1)) dut_2 (
    .clk(clk), .rst(rst), .in_valid(in2_valid), .in_ready(in2_ready), .in_data(in2_data),
    .out_valid(out2_valid), .out_ready(out2_ready), .out_data(out2_data), .busy(busy2));

  bitonic_sort_seq #(.WIDTH(32), .N(256), .ASCENDING(1'b1)) dut_256 (
    .clk(clk), .rst(rst), .in_valid(in3_valid), .in_ready(in3_ready), .in_data(in3_data),
    .out_valid(out3_valid), .out_ready(out3_ready), .out_data(out3_data), .busy(busy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input word_t act, input word_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: insertion sort into a queue.
  function automatic wq_t sorted(input wq_t a, input bit asc);
    wq_t r;
    int  pos;
    foreach (a[i]) begin
      pos = 0;
      while (pos < r.size() && (asc ? (r[pos] <= a[i]) : (r[pos] >= a[i]))) pos++;
      r.insert(pos, a[i]);
    end
    return r;
  endfunction

  // Protocol monitor on the two N=8 instances.
  always @(negedge clk) begin
    if (!rst)
      check("protocol", 32'({in_ready && (busy || out_valid), !out_valid && (out_data != '0),
                             busy_d != busy, in_ready_d != in_ready}), 0);
  end

  // Ends on the edge that accepts the last word, plus #1.
  task automatic load8(input word_t w[8], input int gap_pct);
    int idx = 0;
    int guard = 0;
    while (idx < 8 && guard < 4000) begin
      @(negedge clk);
      guard++;
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = w[idx];
      if (in_valid && in_ready) idx++;
    end
    check("load_done", idx, 8);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 10000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic unload8(input int stall_pct, output word_t ga[8], output word_t gd[8]);
    int    n = 0;
    int    guard = 0;
    bit    held = 1'b0;
    word_t hd = '0;
    while (n < 8 && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (held) check("stall_hold", out_data, hd);
      out_ready = ($urandom_range(99) >= stall_pct);
      if (out_valid && out_ready) begin
        ga[n] = out_data;
        gd[n] = out_data_d;
        check("desc_valid", 32'(out_valid_d), 1);
        n++;
      end
      held = out_valid && !out_ready;
      hd   = out_data;
    end
    check("unload_done", n, 8);
  endtask

  // Called right after load8: checks SORT status, latency, data, and return to LOAD.
  task automatic finish8(input word_t ea[8], input word_t ed[8], input int stall_pct);
    int    n;
    word_t ga[8], gd[8];
    check("busy_in_sort", 32'({busy, in_ready}), 32'b10);
    wait_out(n);
    check("latency", n, 31);
    unload8(stall_pct, ga, gd);
    for (int i = 0; i < 8; i++) begin
      check("out_asc", ga[i], ea[i]);
      check("out_desc", gd[i], ed[i]);
    end
    @(posedge clk);
    #1;
    check("idle_after_unload", 32'({busy, out_valid, in_ready}), 32'b001);
  endtask

  task automatic run_x(input bit big, input wq_t w, input int exp_lat);
    int  idx = 0;
    int  guard = 0;
    wq_t got, exp;
    while (idx < w.size() && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (big) begin
        in3_valid = 1'b1; in3_data = w[idx];
        if (in3_ready) idx++;
      end else begin
        in2_valid = 1'b1; in2_data = w[idx];
        if (in2_ready) idx++;
      end
    end
    check("x_load_done", idx, w.size());
    @(posedge clk);
    #1;
    in2_valid = 1'b0;
    in3_valid = 1'b0;
    check("x_busy", 32'(big ? busy3 : busy2), 1);
    guard = 0;
    while (!(big ? out3_valid : out2_valid) && guard < 10000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("x_latency", guard, exp_lat);
    out2_ready = 1'b1;
    out3_ready = 1'b1;
    guard = 0;
    while (got.size() < w.size() && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (big ? out3_valid : out2_valid) got.push_back(big ? out3_data : out2_data);
    end
    check("x_unload_done", got.size(), w.size());
    exp = sorted(w, 1'b1);
    for (int i = 0; i < got.size(); i++) check("x_out", got[i], exp[i]);
  endtask

  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    word_t w[8], ea[8], ed[8], ga[8];
    wq_t   q, qa, qd;
    int    n;

    vecs[0].din = {32'd5, 32'd3, 32'd7, 32'd1, 32'd8, 32'd2, 32'd6, 32'd4};
    vecs[0].asc = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    vecs[0].dsc = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    vecs[1].din = {32'd2, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd1, 32'd1};
    vecs[1].asc = {32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd2, 32'hFFFFFFFF};
    vecs[1].dsc = {32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0};
    vecs[2].din = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    vecs[2].asc = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    vecs[2].dsc = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    vecs[3].din = {32'd40, 32'd10, 32'd70, 32'd20, 32'd60, 32'd30, 32'd80, 32'd50};
    vecs[3].asc = {32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80};
    vecs[3].dsc = {32'd80, 32'd70, 32'd60, 32'd50, 32'd40, 32'd30, 32'd20, 32'd10};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in2_valid = 1'b0; in2_data = '0; out2_ready = 1'b0;
    in3_valid = 1'b0; in3_data = '0; out3_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 32'({in_ready, out_valid, busy, in2_ready, in3_ready}), 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", 32'({in_ready, in2_ready, in3_ready}), 32'b111);

    // Table vectors, full rate
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 8; i++) begin
        w[i] = vecs[t].din[i]; ea[i] = vecs[t].asc[i]; ed[i] = vecs[t].dsc[i];
      end
      load8(w, 0);
      finish8(ea, ed, 0);
    end

    // Back-to-back: new word offered during the final output transfer
    for (int i = 0; i < 8; i++) w[i] = vecs[0].din[i];
    load8(w, 0);
    wait_out(n);
    check("b2b_latency", n, 31);
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      out_ready = 1'b1;
      check("b2b_valid", 32'(out_valid), 1);
      ga[n] = out_data;
      n++;
      if (n == 8) begin
        in_valid = 1'b1;
        in_data  = vecs[3].din[0];
        check("b2b_in_ready_low", 32'(in_ready), 0);
      end
    end
    @(posedge clk);
    #1;
    check("b2b_in_ready_high", 32'(in_ready), 1);
    for (int i = 0; i < 8; i++) check("b2b_first_block", ga[i], vecs[0].asc[i]);
    for (int i = 0; i < 8; i++) begin
      w[i] = vecs[3].din[i]; ea[i] = vecs[3].asc[i]; ed[i] = vecs[3].dsc[i];
    end
    load8(w, 0);
    finish8(ea, ed, 0);

    // Reset during SORT pass 3, then a fresh 8..1 block
    for (int i = 0; i < 8; i++) w[i] = vecs[0].din[i];
    load8(w, 0);
    repeat (12) @(posedge clk);
    #1;
    check("busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_sort", 32'({out_valid, busy, in_ready}), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w[i] = vecs[2].din[i]; ea[i] = vecs[2].asc[i]; ed[i] = vecs[2].dsc[i];
    end
    load8(w, 0);
    finish8(ea, ed, 0);

    // Reset mid-UNLOAD, then a fresh 8..1 block
    for (int i = 0; i < 8; i++) w[i] = vecs[0].din[i];
    load8(w, 0);
    wait_out(n);
    repeat (3) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_unload", 32'({out_valid, busy}), 0);
    check("rst_in_unload_data", out_data, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_partial_output", 32'(out_valid), 0);
    for (int i = 0; i < 8; i++) w[i] = vecs[2].din[i];
    load8(w, 0);
    finish8(ea, ed, 0);

    // N=2: {9,4}; N=256 random
    q = {32'd9, 32'd4};
    run_x(1'b0, q, 3);
    q = {};
    for (int i = 0; i < 256; i++) q.push_back($urandom);
    run_x(1'b1, q, 36 * 129 + 1);

    // Random blocks with input gaps and output stalls
    for (int b = 0; b < 1000; b++) begin
      q = {};
      for (int i = 0; i < 8; i++) begin
        w[i] = ($urandom_range(3) == 0) ? word_t'($urandom_range(3)) : word_t'($urandom);
        q.push_back(w[i]);
      end
      qa = sorted(q, 1'b1);
      qd = sorted(q, 1'b0);
      for (int i = 0; i < 8; i++) begin
        ea[i] = qa[i]; ed[i] = qd[i];
      end
      load8(w, 50);
      finish8(ea, ed, 50);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
